// File: rtl/fetch_req_ctrl.sv
// Sequential instruction fetch with credit-based flow control into a fetch buffer.
// Redirects (flush / exception / ertn) retarget the PC and discard in-flight responses.
module fetch_req_ctrl #(
    parameter int          DEPTH    = 16,
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        excp_flush,
    input  logic [31:0] excp_pc,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_pc,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [31:0] inst_req_addr,
    input  logic        inst_resp_valid,
    input  logic [31:0] inst_resp_data,
    input  logic        inst_resp_err,
    output logic        buf_valid,
    input  logic        buf_ready,
    output logic [63:0] buf_bus,
    output logic        buf_excp,
    output logic [3:0]  buf_excp_num,
    input  logic        buf_pop
);
    localparam int CW = $clog2(DEPTH + MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_MAXOUT = CW'(MAX_OUT);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [PW-1:0] P_LAST   = PW'(MAX_OUT - 1);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_pc_fifo [MAX_OUT];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic          w_redirect;
    logic [31:0]   w_target;
    logic          w_run;
    logic          w_credit_ok;
    logic          w_aligned;
    logic          w_req_hs;
    logic          w_resp_push;
    logic          w_adef_push;
    logic          w_push;
    logic [CW-1:0] w_out_nxt;

    assign w_redirect  = excp_flush | ertn_flush | flush;
    assign w_target    = excp_flush ? excp_pc : (ertn_flush ? ertn_pc : flush_pc);
    assign w_run       = !reset && (r_state == S_RUN) && !w_redirect;
    assign w_credit_ok = (r_occ + r_out) < C_DEPTH;
    assign w_aligned   = (r_pc[1:0] == 2'b00);

    assign inst_req_valid = w_run && (r_out < C_MAXOUT) && w_credit_ok && w_aligned;
    assign inst_req_addr  = r_pc;
    assign w_req_hs       = inst_req_valid && inst_req_ready;

    // Responses still owed from before a redirect are swallowed, never pushed
    assign w_resp_push = !reset && inst_resp_valid && (r_drop == '0) && !w_redirect;
    assign w_adef_push = w_run && !w_aligned && w_credit_ok && (r_out == '0);
    assign buf_valid   = w_resp_push || w_adef_push;
    assign w_push      = buf_valid && buf_ready;

    assign w_out_nxt = r_out + (w_req_hs ? C_ONE : '0) - (inst_resp_valid ? C_ONE : '0);

    always_comb begin
        buf_bus      = '0;
        buf_excp     = 1'b0;
        buf_excp_num = 4'h0;
        if (w_resp_push) begin
            buf_bus      = {r_pc_fifo[r_rd_ptr], (inst_resp_err ? 32'h0 : inst_resp_data)};
            buf_excp     = inst_resp_err;
            buf_excp_num = inst_resp_err ? 4'h2 : 4'h0;
        end else if (w_adef_push) begin
            buf_bus      = {r_pc, 32'h0};
            buf_excp     = 1'b1;
            buf_excp_num = 4'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_occ    <= '0;
            r_out    <= '0;
            r_drop   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_redirect) begin
                r_pc    <= w_target;
                r_state <= S_RUN;
                r_occ   <= '0;
                r_drop  <= w_out_nxt;
            end else begin
                if (w_req_hs)
                    r_pc <= r_pc + 32'd4;
                if (w_adef_push)
                    r_state <= S_HALT;
                r_occ <= r_occ + (w_push ? C_ONE : '0) - (buf_pop ? C_ONE : '0);
                if (inst_resp_valid && (r_drop != '0))
                    r_drop <= r_drop - C_ONE;
            end
            r_out <= w_out_nxt;
            if (w_req_hs)
                r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PW'(1);
            if (inst_resp_valid)
                r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PW'(1);
        end
    end

    // PC of each request, consumed in order by its response (dropped or not)
    always_ff @(posedge clk) begin
        if (w_req_hs)
            r_pc_fifo[r_wr_ptr] <= r_pc;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(buf_valid && !buf_ready)) else $error("fetch buffer refused a push");
            assert (!(inst_resp_valid && (r_out == '0))) else $error("response with nothing outstanding");
            assert (!(buf_pop && (r_occ == '0) && !w_redirect)) else $error("pop from empty buffer");
            assert ((r_occ + r_out) <= C_DEPTH) else $error("credit overflow");
            assert (r_drop <= r_out) else $error("drop count exceeds outstanding");
        end
    end
`endif
endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Directed bench for fetch_req_ctrl with an in-order memory model of configurable latency.
module tb_fetch_req_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        excp_flush;
    logic [31:0] excp_pc;
    logic        ertn_flush;
    logic [31:0] ertn_pc;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_req_addr;
    logic        inst_resp_valid;
    logic [31:0] inst_resp_data;
    logic        inst_resp_err;
    logic        buf_valid;
    logic        buf_ready;
    logic [63:0] buf_bus;
    logic        buf_excp;
    logic [3:0]  buf_excp_num;
    logic        buf_pop;

    fetch_req_ctrl #(.DEPTH(16), .MAX_OUT(4), .RESET_PC(32'h1c000000)) dut (
        .clk(clk), .reset(reset),
        .flush(flush), .flush_pc(flush_pc),
        .excp_flush(excp_flush), .excp_pc(excp_pc),
        .ertn_flush(ertn_flush), .ertn_pc(ertn_pc),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_req_addr(inst_req_addr),
        .inst_resp_valid(inst_resp_valid), .inst_resp_data(inst_resp_data),
        .inst_resp_err(inst_resp_err),
        .buf_valid(buf_valid), .buf_ready(buf_ready), .buf_bus(buf_bus),
        .buf_excp(buf_excp), .buf_excp_num(buf_excp_num), .buf_pop(buf_pop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] req_q[$];
    int          req_cyc[$];
    logic [68:0] push_q[$];
    int          cyc;
    int          lat;
    int          out_cnt;
    int          out_max;
    logic        resp_en;
    logic [31:0] err_addr;
    int          checks;
    int          errors;
    int          nr;
    int          np;

    function automatic logic [68:0] ent(logic e, logic [3:0] n, logic [31:0] pc, logic [31:0] inst);
        return {e, n, pc, inst};
    endfunction

    task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: log this cycle's handshakes/pushes, then drive the memory response for the next
    task automatic tick();
        logic [31:0] a;
        #1;
        if (inst_req_valid && inst_req_ready) begin
            pend.push_back('{addr: inst_req_addr, due: cyc + lat});
            req_q.push_back(inst_req_addr);
            req_cyc.push_back(cyc);
            out_cnt++;
        end
        if (inst_resp_valid) out_cnt--;
        if (out_cnt > out_max) out_max = out_cnt;
        if (buf_valid && buf_ready) push_q.push_back({buf_excp, buf_excp_num, buf_bus});
        @(posedge clk);
        cyc++;
        #1;
        if (resp_en && pend.size() > 0 && pend[0].due <= cyc) begin
            a = pend[0].addr;
            pend.pop_front();
            inst_resp_valid = 1'b1;
            inst_resp_data  = ~a;
            inst_resp_err   = (a == err_addr);
        end else begin
            inst_resp_valid = 1'b0;
            inst_resp_data  = 32'h0;
            inst_resp_err   = 1'b0;
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inst_resp_valid = 1'b0;
        pend.delete();
        out_cnt = 0;
        ticks(2);
        req_q.delete();
        req_cyc.delete();
        push_q.delete();
        out_max = 0;
        reset = 1'b0;
        #1;
    endtask

    task automatic redirect(logic f, logic [31:0] fpc, logic x, logic [31:0] xpc, logic r, logic [31:0] rpc);
        flush = f; flush_pc = fpc;
        excp_flush = x; excp_pc = xpc;
        ertn_flush = r; ertn_pc = rpc;
        tick();
        flush = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1; out_cnt = 0; out_max = 0;
        resp_en = 1'b1; err_addr = 32'hffffffff;
        reset = 1'b1; flush = 1'b0; flush_pc = '0; excp_flush = 1'b0; excp_pc = '0;
        ertn_flush = 1'b0; ertn_pc = '0; inst_req_ready = 1'b1; inst_resp_valid = 1'b0;
        inst_resp_data = '0; inst_resp_err = 1'b0; buf_ready = 1'b1; buf_pop = 1'b0;
        ticks(3);
        #1;
        chk("rst_req_valid", 72'(inst_req_valid), 72'(0));
        chk("rst_req_addr", 72'(inst_req_addr), 72'(32'h1c000000));
        chk("rst_buf_valid", 72'(buf_valid), 72'(0));
        chk("rst_buf_excp", 72'({buf_excp, buf_excp_num, buf_bus}), 72'(0));

        // Streaming with no pops: credit stops fetch after 16 requests
        reset = 1'b0;
        #1;
        chk("first_req_valid", 72'(inst_req_valid), 72'(1));
        chk("first_req_addr", 72'(inst_req_addr), 72'(32'h1c000000));
        ticks(30);
        chk("credit_req_count", 72'(req_q.size()), 72'(16));
        chk("last_req_addr", 72'(req_q[15]), 72'(32'h1c00003c));
        chk("full_throughput", 72'(req_cyc[15] - req_cyc[0]), 72'(15));
        chk("push_count", 72'(push_q.size()), 72'(16));
        chk("first_push", 72'(push_q[0]), 72'(ent(1'b0, 4'h0, 32'h1c000000, ~32'h1c000000)));
        chk("push_5", 72'(push_q[5]), 72'(ent(1'b0, 4'h0, 32'h1c000014, ~32'h1c000014)));
        chk("stalled_valid", 72'(inst_req_valid), 72'(0));
        buf_pop = 1'b1;
        tick();
        buf_pop = 1'b0;
        ticks(10);
        chk("pop_one_more_req", 72'(req_q.size()), 72'(17));
        chk("pop_req_addr", 72'(req_q[16]), 72'(32'h1c000040));

        // Slow memory: outstanding limit
        lat = 6;
        do_reset();
        ticks(6);
        chk("maxout_reqs_6cyc", 72'(req_q.size()), 72'(4));
        ticks(6);
        chk("maxout_peak", 72'(out_max), 72'(4));
        chk("maxout_more_reqs", 72'(req_q.size()), 72'(8));

        // Three outstanding, then flush: old responses are dropped
        lat = 1;
        resp_en = 1'b0;
        do_reset();
        ticks(3);
        flush = 1'b1; flush_pc = 32'h1c000100;
        #1;
        chk("flush_gates_valid", 72'(inst_req_valid), 72'(0));
        nr = req_q.size();
        redirect(1'b1, 32'h1c000100, 1'b0, '0, 1'b0, '0);
        resp_en = 1'b1;
        ticks(12);
        chk("flush_pre_reqs", 72'(nr), 72'(3));
        chk("flush_first_req", 72'(req_q[nr]), 72'(32'h1c000100));
        chk("flush_first_push", 72'(push_q[0]), 72'(ent(1'b0, 4'h0, 32'h1c000100, ~32'h1c000100)));
        chk("flush_second_push", 72'(push_q[1]), 72'(ent(1'b0, 4'h0, 32'h1c000104, ~32'h1c000104)));

        // Exception beats flush when both fire together
        nr = req_q.size();
        redirect(1'b1, 32'h1c000200, 1'b1, 32'h1c008000, 1'b0, '0);
        chk("excp_prio_valid", 72'(inst_req_valid), 72'(1));
        chk("excp_prio_addr", 72'(inst_req_addr), 72'(32'h1c008000));
        tick();
        chk("excp_prio_req", 72'(req_q[nr]), 72'(32'h1c008000));
        ticks(3);

        // Misaligned ertn target: one ADEF entry then silence
        nr = req_q.size();
        np = push_q.size();
        redirect(1'b0, '0, 1'b0, '0, 1'b1, 32'h1c000102);
        ticks(6);
        chk("adef_no_req", 72'(req_q.size()), 72'(nr));
        chk("adef_one_push", 72'(push_q.size()), 72'(np + 1));
        chk("adef_entry", 72'(push_q[np]), 72'(ent(1'b1, 4'h1, 32'h1c000102, 32'h0)));
        ticks(4);
        #1;
        chk("halt_req_valid", 72'(inst_req_valid), 72'(0));
        chk("halt_buf_valid", 72'(buf_valid), 72'(0));
        chk("halt_silent", 72'(push_q.size()), 72'(np + 1));
        redirect(1'b0, '0, 1'b1, 32'h1c008000, 1'b0, '0);
        chk("resume_valid", 72'(inst_req_valid), 72'(1));
        chk("resume_addr", 72'(inst_req_addr), 72'(32'h1c008000));
        ticks(4);
        chk("resume_push", 72'(push_q[np + 1]), 72'(ent(1'b0, 4'h0, 32'h1c008000, ~32'h1c008000)));

        // Bus error on one response
        err_addr = 32'h1c000010;
        np = push_q.size();
        redirect(1'b1, 32'h1c000008, 1'b0, '0, 1'b0, '0);
        ticks(8);
        chk("err_push0", 72'(push_q[np]), 72'(ent(1'b0, 4'h0, 32'h1c000008, ~32'h1c000008)));
        chk("err_push1", 72'(push_q[np + 1]), 72'(ent(1'b0, 4'h0, 32'h1c00000c, ~32'h1c00000c)));
        chk("err_entry", 72'(push_q[np + 2]), 72'(ent(1'b1, 4'h2, 32'h1c000010, 32'h0)));
        chk("err_after", 72'(push_q[np + 3]), 72'(ent(1'b0, 4'h0, 32'h1c000014, ~32'h1c000014)));

        // 32-bit PC wrap
        nr = req_q.size();
        np = push_q.size();
        redirect(1'b1, 32'hfffffffc, 1'b0, '0, 1'b0, '0);
        ticks(4);
        chk("wrap_req0", 72'(req_q[nr]), 72'(32'hfffffffc));
        chk("wrap_req1", 72'(req_q[nr + 1]), 72'(32'h00000000));
        chk("wrap_push1", 72'(push_q[np + 1]), 72'(ent(1'b0, 4'h0, 32'h00000000, 32'hffffffff)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
